// File: rtl/vga_frame_capture.sv
// vga_frame_capture: recovers the P_PARAM_N x P_PARAM_M cell grid from a VGA pixel stream by
//   sampling every cell at its centre (white = alive). It publishes the grid after each well-formed frame.
// Latency: status, frame_valid and frame_error change on the 2nd clk edge after vsync goes active.
// Backpressure: none. The pixel stream cannot be stalled, and malformed frames are dropped (frame_error).
// Ports: clk, reset (async, active-high); hsync, vsync, data_enable, video_red/green/blue in;
//   status (bit row*P_PARAM_N+col, 1 = alive), frame_valid, frame_error, locked out.
// Optional: define VGA_CAP_STATS_EN to add frame_count[15:0] (wraps) and error_count[7:0] (saturates).
module vga_frame_capture #(
    parameter int WIDTH     = 12,
    parameter int HSIZE     = 800,
    parameter int VSIZE     = 600,
    parameter int HSPP      = 1,
    parameter int VSPP      = 1,
    parameter int P_PARAM_N = 25,
    parameter int P_PARAM_M = 18
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           hsync,
    input  logic                           vsync,
    input  logic                           data_enable,
    input  logic [7:0]                     video_red,
    input  logic [7:0]                     video_green,
    input  logic [7:0]                     video_blue,
    output logic [P_PARAM_N*P_PARAM_M-1:0] status,
    output logic                           frame_valid,
    output logic                           frame_error,
    output logic                           locked
`ifdef VGA_CAP_STATS_EN
    ,
    output logic [15:0]                    frame_count,
    output logic [7:0]                     error_count
`endif
);

    localparam int NCELL = P_PARAM_N * P_PARAM_M;
    localparam int CELL  = HSIZE / P_PARAM_N;
    localparam int SOFF  = CELL / 2;
    localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;

    localparam logic [WIDTH-1:0] HSIZE_W = WIDTH'(HSIZE);
    localparam logic [WIDTH-1:0] XMAX_W  = WIDTH'(HSIZE + 1);
    localparam logic [WIDTH-1:0] VSIZE_W = WIDTH'(VSIZE);
    localparam logic [WIDTH-1:0] CLAST_W = WIDTH'(CELL - 1);
    localparam logic [WIDTH-1:0] SOFF_W  = WIDTH'(SOFF);
    localparam logic [WIDTH-1:0] NCOL_W  = WIDTH'(P_PARAM_N);
    localparam logic [WIDTH-1:0] NROW_W  = WIDTH'(P_PARAM_M);
    localparam logic             HS_ACT  = 1'(HSPP);
    localparam logic             VS_ACT  = 1'(VSPP);

    typedef enum logic {SEEK, CAPTURE} state_t;

    state_t state, next_state;

    // Input stage
    logic       hs_r, vs_r, de_r;
    logic       vs_q, de_q;
    logic [7:0] red_r, green_r, blue_r;

    // Position tracking: x/y are the raw pixel/line counts within the frame.
    // The (sub, cell) pairs track x%CELL, x/CELL and y%CELL, y/CELL incrementally.
    // This avoids dividers. Cell indices stop at the grid edge, which is all the sampler needs.
    logic [WIDTH-1:0] x, y;
    logic [WIDTH-1:0] x_sub, x_cell, y_sub, y_cell;
    logic             bad;
    logic [NCELL-1:0] shadow;

    logic             vs_edge, de_fall, hs_act, alive, sample;
    logic             bad_now, frame_ok;
    logic [WIDTH-1:0] y_inc, y_eval;
    logic [IW-1:0]    idx;
    logic             frame_start, commit, reject;

    always_comb begin
        vs_edge = (vs_r == VS_ACT) && (vs_q != VS_ACT);
        de_fall = de_q && !de_r;
        hs_act  = (hs_r == HS_ACT);
        alive   = (red_r >= 8'h80) && (green_r >= 8'h80) && (blue_r >= 8'h80);
        sample  = de_r && (x_sub == SOFF_W) && (x_cell < NCOL_W) &&
                  (y_sub == SOFF_W) && (y_cell < NROW_W);
        idx     = IW'(y_cell * NCOL_W + x_cell);
        y_inc   = (&y) ? y : y + 1'b1;
        // Events in the same cycle as the vsync edge are applied before the
        // frame is judged. Data during sync or a line ending now both count.
        y_eval  = de_fall ? y_inc : y;
        bad_now = bad || (de_fall && (x != HSIZE_W)) || (de_r && hs_act) ||
                  (de_r && vs_edge);
        frame_ok = !bad_now && (y_eval == VSIZE_W);
    end

    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        commit      = 1'b0;
        reject      = 1'b0;
        case (state)
            SEEK: begin
                if (vs_edge) begin
                    next_state  = CAPTURE;
                    frame_start = 1'b1;
                end
            end
            CAPTURE: begin
                if (vs_edge) begin
                    frame_start = 1'b1;
                    commit      = frame_ok;
                    reject      = !frame_ok;
                end
            end
            default: next_state = SEEK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEEK;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_r        <= 1'b0;
            vs_r        <= 1'b0;
            de_r        <= 1'b0;
            vs_q        <= 1'b0;
            de_q        <= 1'b0;
            red_r       <= 8'h00;
            green_r     <= 8'h00;
            blue_r      <= 8'h00;
            x           <= '0;
            y           <= '0;
            x_sub       <= '0;
            x_cell      <= '0;
            y_sub       <= '0;
            y_cell      <= '0;
            bad         <= 1'b0;
            shadow      <= '0;
            status      <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            locked      <= 1'b0;
        end else begin
            hs_r        <= hsync;
            vs_r        <= vsync;
            de_r        <= data_enable;
            vs_q        <= vs_r;
            de_q        <= de_r;
            red_r       <= video_red;
            green_r     <= video_green;
            blue_r      <= video_blue;
            frame_valid <= commit;
            frame_error <= reject;
            if (commit) begin
                status <= shadow;
                locked <= 1'b1;
            end

            if (frame_start) begin
                x      <= '0;
                y      <= '0;
                x_sub  <= '0;
                x_cell <= '0;
                y_sub  <= '0;
                y_cell <= '0;
                bad    <= 1'b0;
            end else if (state == CAPTURE) begin
                if (de_r) begin
                    // x stops at HSIZE+1 so an over-long line can never wrap back to HSIZE.
                    if (x != XMAX_W) begin
                        x <= x + 1'b1;
                    end
                    if (x_cell < NCOL_W) begin
                        if (x_sub == CLAST_W) begin
                            x_sub  <= '0;
                            x_cell <= x_cell + 1'b1;
                        end else begin
                            x_sub <= x_sub + 1'b1;
                        end
                    end
                    if (hs_act) begin
                        bad <= 1'b1;
                    end
                    if (sample) begin
                        shadow[idx] <= alive;
                    end
                end else if (de_fall) begin
                    if (x != HSIZE_W) begin
                        bad <= 1'b1;
                    end
                    y      <= y_inc;
                    x      <= '0;
                    x_sub  <= '0;
                    x_cell <= '0;
                    if (y_cell < NROW_W) begin
                        if (y_sub == CLAST_W) begin
                            y_sub  <= '0;
                            y_cell <= y_cell + 1'b1;
                        end else begin
                            y_sub <= y_sub + 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef VGA_CAP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= 16'h0000;
            error_count <= 8'h00;
        end else begin
            if (commit) begin
                frame_count <= frame_count + 16'h0001;
            end
            if (reject && (error_count != 8'hFF)) begin
                error_count <= error_count + 8'h01;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: drives synthetic VGA frames into a small-grid vga_frame_capture.
// It compares every frame outcome against a pixel-level reference model of the capture rules.
// Clean frames, malformed frames, colour thresholds, data during sync and mid-frame reset are covered.
module tb_vga_frame_capture;

    localparam int HS   = 8;
    localparam int VS   = 8;
    localparam int NN   = 2;
    localparam int MM   = 2;
    localparam int CELL = HS / NN;
    localparam int SOFF = CELL / 2;
    localparam int NC   = NN * MM;

    logic          clk = 1'b0;
    logic          rst;
    logic          hs, vs, de;
    logic [7:0]    red, grn, blu;
    logic [NC-1:0] status;
    logic          frame_valid, frame_error, locked;
`ifdef VGA_CAP_STATS_EN
    logic [15:0]   frame_count;
    logic [7:0]    error_count;
`endif

    vga_frame_capture #(
        .WIDTH(12), .HSIZE(HS), .VSIZE(VS), .HSPP(1), .VSPP(1),
        .P_PARAM_N(NN), .P_PARAM_M(MM)
    ) dut (
        .clk(clk),
        .reset(rst),
        .hsync(hs),
        .vsync(vs),
        .data_enable(de),
        .video_red(red),
        .video_green(grn),
        .video_blue(blu),
        .status(status),
        .frame_valid(frame_valid),
        .frame_error(frame_error),
        .locked(locked)
`ifdef VGA_CAP_STATS_EN
        ,
        .frame_count(frame_count),
        .error_count(error_count)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Frame image handed to send_frame
    logic [23:0] pix [16][16];
    int          llen [16];
    int          nlines;

    // Reference model state
    bit          m_cap;
    bit          m_bad;
    int          m_lines;
    logic [NC-1:0] m_shadow, m_status;
    bit          m_locked;
    int          m_fc, m_ec;

    typedef struct {
        logic [23:0] rgb;
        logic        alive;
    } col_vec_t;

    col_vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_white(input logic [23:0] c);
        return (c[23:16] >= 8'h80) && (c[15:8] >= 8'h80) && (c[7:0] >= 8'h80);
    endfunction

    task automatic model_reset();
        m_cap = 0; m_bad = 0; m_lines = 0;
        m_shadow = '0; m_status = '0; m_locked = 0;
        m_fc = 0; m_ec = 0;
    endtask

    task automatic fill_solid(input logic [23:0] c);
        for (int l = 0; l < 16; l++)
            for (int p = 0; p < 16; p++) pix[l][p] = c;
        for (int l = 0; l < 16; l++) llen[l] = HS;
        nlines = VS;
    endtask

    // Right half of the screen white, left half black: status 4'b1010.
    task automatic fill_checker();
        fill_solid(24'h000000);
        for (int l = 0; l < 16; l++)
            for (int p = CELL; p < 16; p++) pix[l][p] = 24'hFFFFFF;
    endtask

    task automatic send_frame(input int glitch_line);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < llen[l]; p++) begin
                de = 1'b1;
                {red, grn, blu} = pix[l][p];
                hs = (l == glitch_line) && (p == 0);
                if (m_cap) begin
                    if (hs) m_bad = 1;
                    if ((p % CELL == SOFF) && (m_lines % CELL == SOFF) &&
                        (p / CELL < NN) && (m_lines / CELL < MM))
                        m_shadow[(m_lines / CELL) * NN + p / CELL] = is_white(pix[l][p]);
                end
                tick();
            end
            de = 1'b0; hs = 1'b0; {red, grn, blu} = 24'h0;
            tick();
            hs = 1'b1; tick(); tick();
            hs = 1'b0; tick();
            if (m_cap) begin
                if (llen[l] != HS) m_bad = 1;
                m_lines++;
            end
        end
    endtask

    task automatic vsync_edge(input bit de_during);
        bit exp_v, exp_e;
        exp_v = 0; exp_e = 0;
        tick(); tick();
        if (!m_cap) begin
            m_cap = 1;
        end else if (!m_bad && !de_during && m_lines == VS) begin
            exp_v = 1; m_status = m_shadow; m_locked = 1;
            m_fc = (m_fc + 1) & 16'hFFFF;
        end else begin
            exp_e = 1;
            if (m_ec < 255) m_ec++;
        end
        // A DE cycle coinciding with the sync edge leaves an empty line at the
        // start of the next frame: one extra line, and a bad length.
        m_bad   = de_during;
        m_lines = de_during ? 1 : 0;
        vs = 1'b1; de = de_during;
        tick();
        chk("pulse_early", {30'd0, frame_valid, frame_error}, 32'd0);
        de = 1'b0;
        tick();
        chk("frame_valid", 32'(frame_valid), 32'(exp_v));
        chk("frame_error", 32'(frame_error), 32'(exp_e));
        chk("status", 32'(status), 32'(m_status));
        chk("locked", 32'(locked), 32'(m_locked));
`ifdef VGA_CAP_STATS_EN
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        chk("error_count", 32'(error_count), 32'(m_ec));
`endif
        tick();
        chk("pulse_width", {30'd0, frame_valid, frame_error}, 32'd0);
        vs = 1'b0;
        tick(); tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, l;
        tbl[0] = '{24'h807F80, 1'b0};
        tbl[1] = '{24'h808080, 1'b1};
        tbl[2] = '{24'hFFFFFF, 1'b1};
        tbl[3] = '{24'h000000, 1'b0};
        tbl[4] = '{24'h7FFFFF, 1'b0};
        tbl[5] = '{24'hFFFF7F, 1'b0};
        tbl[6] = '{24'hC09081, 1'b1};
        tbl[7] = '{24'hFF7FFF, 1'b0};

        rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0;
        red = 8'h0; grn = 8'h0; blu = 8'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_pulses", {29'd0, frame_valid, frame_error, locked}, 32'd0);
        rst = 1'b0;
        tick();

        // The first sync edge only arms capture; the next frame commits.
        fill_checker();
        send_frame(-1);
        vsync_edge(0);
        send_frame(-1);
        vsync_edge(0);
        chk("checker_status", 32'(status), 32'h0000000A);

        // Colour classification table: a solid frame makes every cell equal the verdict.
        for (int i = 0; i < 8; i++) begin
            fill_solid(tbl[i].rgb);
            send_frame(-1);
            vsync_edge(0);
            chk("colour_table", 32'(status), {28'd0, {4{tbl[i].alive}}});
        end

        // Single white pixel at (2,6) lands in row 1, column 0.
        fill_solid(24'h000000);
        pix[6][2] = 24'hFFFFFF;
        send_frame(-1);
        vsync_edge(0);
        chk("single_pixel", 32'(status), 32'h4);

        // Short line, missing line, long line, hsync during data: all rejected.
        fill_checker(); llen[3] = 7; send_frame(-1); vsync_edge(0);
        chk("short_keeps", 32'(status), 32'h4);
        fill_checker(); nlines = 7; send_frame(-1); vsync_edge(0);
        fill_checker(); llen[5] = 12; send_frame(-1); vsync_edge(0);
        fill_checker(); send_frame(4); vsync_edge(0);

        // Data during the sync edge: this frame and the next are rejected, then recovery.
        fill_checker(); send_frame(-1); vsync_edge(1);
        send_frame(-1); vsync_edge(0);
        send_frame(-1); vsync_edge(0);
        chk("recovered", 32'(status), 32'hA);

        // Randomised frames with occasional structural faults.
        for (int n = 0; n < 30; n++) begin
            fill_solid(24'h0);
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++) begin
                    pix[a][b] = 24'($urandom);
                    if ($urandom_range(0, 1) == 1) pix[a][b] = pix[a][b] | 24'h808080;
                end
            f = $urandom_range(0, 9);
            l = $urandom_range(0, VS - 1);
            if (f == 0) llen[l] = $urandom_range(1, HS - 1);
            else if (f == 1) llen[l] = $urandom_range(HS + 1, 12);
            else if (f == 2) nlines = $urandom_range(4, VS - 1);
            else if (f == 3) nlines = $urandom_range(VS + 1, 10);
            send_frame((f == 4) ? l : -1);
            vsync_edge(0);
        end

        // Reset in the middle of a frame after a good commit.
        fill_checker(); send_frame(-1); vsync_edge(0);
        nlines = 4; send_frame(-1);
        rst = 1'b1;
        #2;
        chk("midrst_status", 32'(status), 32'd0);
        chk("midrst_flags", {29'd0, frame_valid, frame_error, locked}, 32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        fill_checker(); send_frame(-1); vsync_edge(0);
        send_frame(-1); vsync_edge(0);
        chk("post_rst_commit", 32'(status), 32'hA);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
